fetch_unit: RTL

- Instruction fetch stage; sits directly upstream of the decoder.
- Owns the PC, issues in-order word requests to instruction memory, and buffers returned words in a small queue.
- Presents instruction plus its PC to the decode stage over a valid/ready handshake.
- Accepts a branch/jump redirect from execute and flushes wrong-path instructions, including responses still in flight.

---
 rtl/fetch_unit_if.sv | 34 +++
 rtl/fetch_unit.sv | 173 +++++++++++++++++
 2 files changed

// File: rtl/fetch_unit_if.sv
// fetch_unit_if: bundles the instruction-memory request/response bus, the
// execute-stage redirect and the decode-side valid/ready handshake.
//   imem_req/imem_addr        fetch -> memory request (word address)
//   imem_ready                memory accepts the request this cycle
//   imem_rvalid/imem_rdata    in-order read responses
//   redirect/redirect_pc      taken branch/jump from execute
//   instr_valid/instr_ready   decode handshake
//   instruction/instr_pc      head instruction word and its PC
//   fetch_fault               misaligned redirect target flag
// master: the fetch unit side.  slave: the memory/execute/decode side.
interface fetch_unit_if;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ready;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        instr_valid;
  logic        instr_ready;
  logic [31:0] instruction;
  logic [31:0] instr_pc;
  logic        fetch_fault;

  modport master (
    output imem_req, imem_addr, instr_valid, instruction, instr_pc, fetch_fault,
    input  imem_ready, imem_rvalid, imem_rdata, redirect, redirect_pc, instr_ready
  );

  modport slave (
    input  imem_req, imem_addr, instr_valid, instruction, instr_pc, fetch_fault,
    output imem_ready, imem_rvalid, imem_rdata, redirect, redirect_pc, instr_ready
  );
endinterface

// File: rtl/fetch_unit.sv
// fetch_unit: instruction fetch stage in front of the decoder.
// Owns the PC, issues in-order word requests to instruction memory, buffers
// returned words with their PCs in a DEPTH-entry queue and presents the queue
// head to decode over valid/ready. A redirect from execute flushes the queue
// and discards responses still in flight.
// Ports:
//   clk    rising-edge clock
//   reset  asynchronous active-low reset
//   bus    fetch_unit_if.master (memory bus, redirect, decode handshake)
// Parameters:
//   RESET_PC  first PC fetched after reset
//   DEPTH     queue entries and cap on in-flight plus queued words (2^n, >= 2)
// Optional feature: define MISALIGN_CHECK_EN to flag redirects whose target
// has nonzero low bits (fetch_fault, sticky FAULT state). Without it the low
// target bits are ignored and fetch_fault is tied low.
module fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          DEPTH    = 2
) (
  input  logic         clk,
  input  logic         reset,
  fetch_unit_if.master bus
);

  localparam int          PW      = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int          CW      = PW + 1;
  localparam logic [CW:0] DEPTH_W = (CW+1)'(DEPTH);

  localparam logic [1:0] BOOT  = 2'd0;
  localparam logic [1:0] RUN   = 2'd1;
  localparam logic [1:0] FLUSH = 2'd2;
`ifdef MISALIGN_CHECK_EN
  localparam logic [1:0] FAULT = 2'd3;
`endif

  function automatic logic [31:0] pc_inc(input logic [31:0] pc);
    return pc + 32'd4;
  endfunction

  function automatic logic [31:0] pc_align(input logic [31:0] pc);
    return pc & 32'hFFFF_FFFC;
  endfunction

  // PC of the oldest outstanding request: all non-discarded requests are
  // contiguous words ending just below the current pc.
  function automatic logic [31:0] pc_oldest(input logic [31:0] pc,
                                            input logic [CW-1:0] n);
    return pc - {{(30-CW){1'b0}}, n, 2'b00};
  endfunction

  logic [1:0]    state_p0;
  logic [31:0]   pc_p0;
  logic [CW-1:0] inflight_p0;
  logic [CW-1:0] discard_p0;
`ifdef MISALIGN_CHECK_EN
  logic          fault_p0;
  logic          misalign;
`endif

  logic [31:0]   ins_p1 [DEPTH];
  logic [31:0]   pc_p1  [DEPTH];
  logic [PW-1:0] rd_p1;
  logic [PW-1:0] wr_p1;
  logic [CW-1:0] cnt_p1;

  logic          running;
  logic          vld_p1;
  logic          pop;
  logic          req;
  logic          xfer;
  logic          rsp;
  logic          drop;
  logic          push;
  logic [CW:0]   used;
  logic [CW-1:0] inflight_nx;
  logic [CW-1:0] discard_dec;
  logic [PW-1:0] head_idx;

  always_comb begin
    running     = (state_p0 == RUN) || (state_p0 == FLUSH);
    vld_p1      = (cnt_p1 != '0);
    pop         = vld_p1 && bus.instr_ready;
    // A pop this cycle frees a credit immediately, which keeps one word per
    // cycle flowing with only two entries.
    used        = {1'b0, inflight_p0} + {1'b0, cnt_p1} - {{CW{1'b0}}, pop};
    req         = running && !bus.redirect && (used < DEPTH_W);
    xfer        = req && bus.imem_ready;
    // Stray responses with nothing outstanding (e.g. after reset) are ignored.
    rsp         = bus.imem_rvalid && (inflight_p0 != '0);
    drop        = rsp && ((discard_p0 != '0) || bus.redirect);
    push        = rsp && !drop;
    inflight_nx = inflight_p0 + CW'(xfer) - CW'(rsp);
    discard_dec = discard_p0 - CW'(rsp && (discard_p0 != '0));
    // When empty, show the most recently consumed entry so the outputs hold.
    head_idx    = vld_p1 ? rd_p1 : rd_p1 - PW'(1);
`ifdef MISALIGN_CHECK_EN
    misalign    = (bus.redirect_pc[1:0] != 2'b00);
`endif
  end

  assign bus.imem_req    = req;
  assign bus.imem_addr   = pc_p0;
  assign bus.instr_valid = vld_p1;
  assign bus.instruction = ins_p1[head_idx];
  assign bus.instr_pc    = pc_p1[head_idx];
`ifdef MISALIGN_CHECK_EN
  assign bus.fetch_fault = fault_p0;
`else
  assign bus.fetch_fault = 1'b0;
`endif

  // ---- stage p0: PC, request credits, redirect/flush control ----
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_p0    <= BOOT;
      pc_p0       <= RESET_PC;
      inflight_p0 <= '0;
      discard_p0  <= '0;
`ifdef MISALIGN_CHECK_EN
      fault_p0    <= 1'b0;
`endif
    end else begin
      inflight_p0 <= inflight_nx;
      if (bus.redirect) begin
        pc_p0      <= pc_align(bus.redirect_pc);
        discard_p0 <= inflight_nx;
`ifdef MISALIGN_CHECK_EN
        fault_p0   <= misalign;
        if (misalign) state_p0 <= FAULT;
        else          state_p0 <= (inflight_nx != '0) ? FLUSH : RUN;
`else
        state_p0   <= (inflight_nx != '0) ? FLUSH : RUN;
`endif
      end else begin
        if (xfer) pc_p0 <= pc_inc(pc_p0);
        discard_p0 <= discard_dec;
        case (state_p0)
          BOOT:       state_p0 <= RUN;
          RUN, FLUSH: state_p0 <= (discard_dec != '0) ? FLUSH : RUN;
          default:    state_p0 <= state_p0;
        endcase
      end
    end
  end

  // ---- stage p1: instruction queue ----
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rd_p1  <= '0;
      wr_p1  <= '0;
      cnt_p1 <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        ins_p1[i] <= '0;
        pc_p1[i]  <= '0;
      end
    end else begin
      if (push) begin
        ins_p1[wr_p1] <= bus.imem_rdata;
        pc_p1[wr_p1]  <= pc_oldest(pc_p0, inflight_p0);
      end
      if (bus.redirect) begin
        rd_p1  <= rd_p1 + PW'(pop);
        wr_p1  <= rd_p1 + PW'(pop);
        cnt_p1 <= '0;
      end else begin
        rd_p1  <= rd_p1 + PW'(pop);
        wr_p1  <= wr_p1 + PW'(push);
        cnt_p1 <= cnt_p1 + CW'(push) - CW'(pop);
      end
    end
  end

endmodule
